// File: rtl/pid_axis_sequencer_pkg.sv
// Shared state encoding, axis indices and helpers for the PID axis sequencer.
package pid_axis_sequencer_pkg;

  localparam int unsigned NUM_AXES   = 3;
  localparam int unsigned AXIS_ROLL  = 0;
  localparam int unsigned AXIS_PITCH = 1;
  localparam int unsigned AXIS_YAW   = 2;
  localparam int unsigned STATE_W    = 6;

  // One-hot sequencer states.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 6'b000001,
    ST_START     = 6'b000010,
    ST_WAIT_ACT  = 6'b000100,
    ST_WAIT_DONE = 6'b001000,
    ST_RELEASE   = 6'b010000,
    ST_DONE      = 6'b100000
  } seq_state_e;

  // True when every axis bit of the mask is set.
  function automatic logic all_axes(input logic [NUM_AXES-1:0] mask);
    return &mask;
  endfunction

endpackage

// File: rtl/pid_axis_sequencer_watchdog.sv
// Round watchdog: counts enabled cycles after a clear and flags the last allowed cycle.
module pid_axis_sequencer_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TMO_CNT_WIDTH  = 7
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic count_en_i,
  output logic expired_c_o
);

  localparam logic [TMO_CNT_WIDTH-1:0] LAST_CNT = TMO_CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TMO_CNT_WIDTH-1:0] cnt_q;
  logic [TMO_CNT_WIDTH-1:0] cnt_d;

  // Count up while enabled, holding at the last allowed value.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_en_i && (cnt_q != LAST_CNT)) begin
      cnt_d = cnt_q + TMO_CNT_WIDTH'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_c_o = count_en_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/pid_axis_sequencer.sv
// Starts the roll/pitch/yaw rate PIDs once per IMU sample, collects their results
// and hands one coherent rate set to the motor mixer.
module pid_axis_sequencer
  import pid_axis_sequencer_pkg::*;
#(
  parameter int unsigned RATE_BIT_WIDTH = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TMO_CNT_WIDTH  = 7,
  parameter int unsigned OVR_CNT_WIDTH  = 8
) (
  input  logic                               us_clk,
  input  logic                               reset,
  input  logic                               enable,
  input  logic                               imu_data_valid,
  input  logic [NUM_AXES*RATE_BIT_WIDTH-1:0] pid_rate_in,
  input  logic [NUM_AXES-1:0]                pid_active,
  input  logic [NUM_AXES-1:0]                pid_complete,
  output logic [NUM_AXES-1:0]                start_flag,
  output logic [NUM_AXES-1:0]                wait_flag,
  output logic [RATE_BIT_WIDTH-1:0]          roll_rate,
  output logic [RATE_BIT_WIDTH-1:0]          pitch_rate,
  output logic [RATE_BIT_WIDTH-1:0]          yaw_rate,
  output logic                               rates_valid,
  output logic                               busy,
  output logic                               timeout_err,
  output logic [OVR_CNT_WIDTH-1:0]           overrun_count
);

  seq_state_e state_q, state_d;

  logic [NUM_AXES-1:0]                     done_q, done_d;
  logic [NUM_AXES-1:0][RATE_BIT_WIDTH-1:0] rate_q, rate_d;
  logic                                    round_tmo_q, round_tmo_d;
  logic                                    timeout_err_q, timeout_err_d;
  logic [OVR_CNT_WIDTH-1:0]                ovr_q, ovr_d;
  logic [NUM_AXES-1:0]                     start_q, start_d;
  logic [NUM_AXES-1:0]                     wait_q, wait_d;
  logic                                    rv_q, rv_d;
  logic                                    busy_q, busy_d;

  logic [NUM_AXES-1:0] hit_c;
  logic [NUM_AXES-1:0] new_done_c;
  logic                act_all_c;
  logic                act_none_c;
  logic                wd_clear_c;
  logic                wd_en_c;
  logic                wd_expired_c;
  logic                tmo_hit_c;

  // Axes reporting a fresh result this cycle; rate_out is valid in the same cycle.
  assign hit_c      = (state_q == ST_WAIT_DONE) ? (pid_active & pid_complete & ~done_q) : '0;
  assign new_done_c = done_q | hit_c;
  assign act_all_c  = all_axes(pid_active);
  assign act_none_c = ~|pid_active;
  assign wd_clear_c = (state_q == ST_START);
  assign wd_en_c    = (state_q == ST_WAIT_ACT) || (state_q == ST_WAIT_DONE);
  assign tmo_hit_c  = wd_expired_c &&
                      (((state_q == ST_WAIT_ACT) && !act_all_c) ||
                       ((state_q == ST_WAIT_DONE) && !all_axes(new_done_c)));

  pid_axis_sequencer_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TMO_CNT_WIDTH  (TMO_CNT_WIDTH)
  ) u_watchdog (
    .clk_i       (us_clk),
    .rst_i       (reset),
    .clear_i     (wd_clear_c),
    .count_en_i  (wd_en_c),
    .expired_c_o (wd_expired_c)
  );

  // State register.
  always_ff @(posedge us_clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (imu_data_valid && enable) state_d = ST_START;
      ST_START:     state_d = ST_WAIT_ACT;
      ST_WAIT_ACT: begin
        if (act_all_c)      state_d = ST_WAIT_DONE;
        else if (tmo_hit_c) state_d = ST_RELEASE;
      end
      ST_WAIT_DONE: if (all_axes(new_done_c) || tmo_hit_c) state_d = ST_RELEASE;
      ST_RELEASE:   if (act_none_c) state_d = ST_DONE;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Next values of the output, capture and counter registers.
  always_comb begin
    start_d       = '0;
    wait_d        = '0;
    rv_d          = 1'b0;
    busy_d        = (state_d != ST_IDLE);
    done_d        = done_q;
    rate_d        = rate_q;
    round_tmo_d   = round_tmo_q;
    timeout_err_d = timeout_err_q;
    ovr_d         = ovr_q;

    if (state_d == ST_START)   start_d = '1;
    if (state_d == ST_RELEASE) wait_d  = '1;
    if (state_d == ST_DONE)    rv_d    = !round_tmo_q;

    if (state_q == ST_WAIT_DONE) begin
      done_d = new_done_c;
      for (int unsigned a = 0; a < NUM_AXES; a++) begin
        if (hit_c[a]) rate_d[a] = pid_rate_in[a*RATE_BIT_WIDTH +: RATE_BIT_WIDTH];
      end
    end

    if (tmo_hit_c) begin
      round_tmo_d   = 1'b1;
      timeout_err_d = 1'b1;
    end

    if (state_q == ST_DONE) begin
      done_d      = '0;
      round_tmo_d = 1'b0;
    end

    // Triggers arriving outside IDLE are dropped and counted.
    if (imu_data_valid && (state_q != ST_IDLE) && !(&ovr_q)) begin
      ovr_d = ovr_q + OVR_CNT_WIDTH'(1);
    end
  end

  // Output, capture and counter registers.
  always_ff @(posedge us_clk or posedge reset) begin
    if (reset) begin
      start_q       <= '0;
      wait_q        <= '0;
      rv_q          <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= '0;
      rate_q        <= '0;
      round_tmo_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      ovr_q         <= '0;
    end else begin
      start_q       <= start_d;
      wait_q        <= wait_d;
      rv_q          <= rv_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      rate_q        <= rate_d;
      round_tmo_q   <= round_tmo_d;
      timeout_err_q <= timeout_err_d;
      ovr_q         <= ovr_d;
    end
  end

  assign start_flag    = start_q;
  assign wait_flag     = wait_q;
  assign roll_rate     = rate_q[AXIS_ROLL];
  assign pitch_rate    = rate_q[AXIS_PITCH];
  assign yaw_rate      = rate_q[AXIS_YAW];
  assign rates_valid   = rv_q;
  assign busy          = busy_q;
  assign timeout_err   = timeout_err_q;
  assign overrun_count = ovr_q;

endmodule
